mem_arbiter: RTL and testbench

- Shares one single-port, 32-bit, byte-writable program/data RAM between the core's instruction fetch port and its data port.
- Both core ports use the req/gnt/rvalid protocol.
- Sits inside bus, between the core ports and the RAM macro.
- Grants at most one request per cycle, applies a starvation limit, and returns rvalid/rdata to the port that owns each access.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: response owner encoding and req/gnt/rvalid port bundles.
// Pure type/constant package, no logic.
package bus_pkg;

  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } bus_rsp_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and data ports; grant is combinational, rvalid follows 1 cycle later.
// A losing port is simply not granted; ARB_ROUND_ROBIN_EN swaps data-priority-with-run-limit for round-robin.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int MEM_AW       = 12,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [31:0]       instr_addr,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic [31:0]       instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic contend;
  logic instr_prio;
  logic instr_win;
  logic data_win;
  logic rsp_vld;
  logic rsp_owner;

  assign contend = instr_req & data_req;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int unused_max_run = MAX_DATA_RUN;

  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= OWNER_INSTR;
    end else if (contend) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign instr_prio = (rr_ptr == OWNER_INSTR);
`else
  localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_cnt;

  // Counts data grants that overtook a waiting fetch; saturates so fetch wins next.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (!instr_req || instr_win) begin
      run_cnt <= '0;
    end else if (data_win && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  assign instr_prio = (run_cnt == RUN_MAX);
`endif

  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (!rst) begin
      if (contend) begin
        instr_win = instr_prio;
        data_win  = ~instr_prio;
      end else begin
        instr_win = instr_req;
        data_win  = data_req;
      end
    end
  end

  assign instr_gnt = instr_win;
  assign data_gnt  = data_win;
  assign mem_en    = instr_win | data_win;
  assign mem_addr  = data_win ? data_addr[MEM_AW+1:2] : instr_addr[MEM_AW+1:2];
  assign mem_we    = (data_win && data_we) ? data_be : 4'b0000;
  assign mem_wdata = data_wdata;

  // Byte offset and bits above the RAM size are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[31:MEM_AW+2], instr_addr[1:0],
                              data_addr[31:MEM_AW+2], data_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld   <= 1'b0;
      rsp_owner <= OWNER_INSTR;
    end else begin
      rsp_vld <= mem_en;
      if (mem_en) begin
        rsp_owner <= data_win ? OWNER_DATA : OWNER_INSTR;
      end
    end
  end

  assign instr_rvalid = !rst && rsp_vld && (rsp_owner == OWNER_INSTR);
  assign data_rvalid  = !rst && rsp_vld && (rsp_owner == OWNER_DATA);
  assign instr_rdata  = instr_rvalid ? mem_rdata : 32'h0;
  assign data_rdata   = data_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, behavioural arbitration/response model and directed vectors.
module tb_mem_arbiter;

  localparam int MEM_AW       = 12;
  localparam int MAX_DATA_RUN = 4;
  localparam int WORDS        = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_req = 1'b0;
  logic [31:0]       instr_addr = '0;
  logic              instr_gnt;
  logic              instr_rvalid;
  logic [31:0]       instr_rdata;
  logic              data_req = 1'b0;
  logic              data_we = 1'b0;
  logic [3:0]        data_be = '0;
  logic [31:0]       data_addr = '0;
  logic [31:0]       data_wdata = '0;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  mem_arbiter #(.MEM_AW(MEM_AW), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h41) ? 32'h0000_0013 : (32'h5A5A_0000 | 32'(i));
  endfunction

  // RAM macro stand-in: read-first, data valid the cycle after mem_en.
  logic [31:0] ram [WORDS];
  logic [31:0] model_mem [WORDS];

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]       = init_word(i);
      model_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Behavioural model state: the access granted last cycle and arbitration history.
  logic        m_vld = 1'b0;
  logic        m_is_data = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_data = '0;
  int          m_streak = 0;
  logic        m_turn_data = 1'b0;
  logic        win_on = 1'b0;
  int          win_cyc = 0;
  int          cnt_i = 0;
  int          cnt_d = 0;
  int          cnt_both = 0;
  int          cnt_pat_err = 0;

  always @(negedge clk) begin
    logic              e_ig;
    logic              e_dg;
    logic              e_pat_d;
    logic [MEM_AW-1:0] idx;
    if (instr_gnt && data_gnt) cnt_both++;
    if (rst) begin
      chk1("rst_instr_gnt", instr_gnt, 1'b0);
      chk1("rst_data_gnt", data_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk32("rst_mem_we", 32'(mem_we), 32'h0);
      chk1("rst_instr_rvalid", instr_rvalid, 1'b0);
      chk1("rst_data_rvalid", data_rvalid, 1'b0);
      chk32("rst_data_rdata", data_rdata, 32'h0);
      m_vld       = 1'b0;
      m_streak    = 0;
      m_turn_data = 1'b0;
    end else begin
      chk1("instr_rvalid", instr_rvalid, m_vld && !m_is_data);
      chk1("data_rvalid", data_rvalid, m_vld && m_is_data);
      chk32("instr_rdata", instr_rdata, (m_vld && !m_is_data) ? m_data : 32'h0);
      if (!(m_vld && m_is_data && m_wr))
        chk32("data_rdata", data_rdata, (m_vld && m_is_data) ? m_data : 32'h0);

      if (instr_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        e_dg = m_turn_data;
`else
        e_dg = (m_streak < MAX_DATA_RUN);
`endif
      end else begin
        e_dg = data_req;
      end
      e_ig = instr_req && !e_dg;
      chk1("instr_gnt", instr_gnt, e_ig);
      chk1("data_gnt", data_gnt, e_dg);
      chk1("mem_en", mem_en, e_ig || e_dg);

      m_data = '0;
      if (e_ig || e_dg) begin
        idx = e_dg ? data_addr[MEM_AW+1:2] : instr_addr[MEM_AW+1:2];
        chk32("mem_addr", 32'(mem_addr), 32'(idx));
        chk32("mem_we", 32'(mem_we), (e_dg && data_we) ? 32'(data_be) : 32'h0);
        chk32("mem_wdata", mem_wdata, data_wdata);
        m_data = model_mem[idx];
        if (e_dg && data_we) begin
          for (int b = 0; b < 4; b++) begin
            if (data_be[b]) model_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
          end
        end
      end
      m_vld     = e_ig || e_dg;
      m_is_data = e_dg;
      m_wr      = e_dg && data_we;
      if (!instr_req || e_ig) m_streak = 0;
      else if (e_dg) m_streak++;
      if (instr_req && data_req) m_turn_data = !m_turn_data;

      if (win_on) begin
`ifdef ARB_ROUND_ROBIN_EN
        e_pat_d = (win_cyc % 2) == 1;
`else
        e_pat_d = (win_cyc % 5) != 4;
`endif
        if (data_gnt !== e_pat_d) cnt_pat_err++;
        if (instr_gnt) cnt_i++;
        if (data_gnt) cnt_d++;
        win_cyc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    data_be   = 4'h0;
  endtask

  task automatic ireq(input logic [31:0] a);
    instr_req  = 1'b1;
    instr_addr = a;
  endtask

  task automatic dreq(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = a;
    data_wdata = wd;
  endtask

  task automatic vec(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                     input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    idle();
    if (ir) ireq(ia);
    if (dr) dreq(we, be, da, wd);
    tick();
  endtask

  initial begin
    idle();
    tick();
    tick();
    // Requests during reset must not be granted.
    ireq(32'h104);
    dreq(1'b0, 4'hF, 32'h208, 32'h0);
    @(negedge clk);
    chk1("rst_blocks_instr_gnt", instr_gnt, 1'b0);
    chk1("rst_blocks_data_gnt", data_gnt, 1'b0);
    tick();
    idle();
    rst = 1'b0;

    // Single fetch
    ireq(32'h104);
    @(negedge clk);
    chk1("fetch_gnt", instr_gnt, 1'b1);
    chk32("fetch_mem_addr", 32'(mem_addr), 32'h041);
    tick();
    idle();
    @(negedge clk);
    chk1("fetch_rvalid", instr_rvalid, 1'b1);
    chk32("fetch_rdata", instr_rdata, 32'h0000_0013);
    chk1("fetch_no_data_rvalid", data_rvalid, 1'b0);
    tick();

    // Partial write, then back-to-back readback
    dreq(1'b1, 4'b0011, 32'h208, 32'hAABB_CCDD);
    @(negedge clk);
    chk32("write_mem_we", 32'(mem_we), 32'h3);
    chk32("write_mem_addr", 32'(mem_addr), 32'h082);
    tick();
    dreq(1'b0, 4'hF, 32'h208, 32'h0);
    @(negedge clk);
    chk1("write_rvalid", data_rvalid, 1'b1);
    chk1("readback_gnt_b2b", data_gnt, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk32("readback_rdata", data_rdata, 32'h5A5A_CCDD);
    tick();

    // Aliasing above the RAM size
    dreq(1'b0, 4'hF, 32'h0000_4000, 32'h0);
    @(negedge clk);
    chk32("alias_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    dreq(1'b0, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    chk32("alias_rdata", data_rdata, 32'h5A5A_0000);
    tick();
    idle();
    @(negedge clk);
    chk32("alias_base_rdata", data_rdata, 32'h5A5A_0000);
    tick();

    // Mixed directed vectors
    vec(1'b1, 32'h100,  1'b0, 1'b0, 4'h0,    32'h0,   32'h0);
    vec(1'b1, 32'h100,  1'b1, 1'b1, 4'b1100, 32'h208, 32'h1122_3344);
    vec(1'b0, 32'h0,    1'b1, 1'b0, 4'hF,    32'h208, 32'h0);
    vec(1'b1, 32'h3FFC, 1'b0, 1'b0, 4'h0,    32'h0,   32'h0);
    vec(1'b0, 32'h0,    1'b0, 1'b0, 4'h0,    32'h0,   32'h0);
    vec(1'b1, 32'h8,    1'b1, 1'b1, 4'b0001, 32'h20,  32'h0000_00EE);
    vec(1'b1, 32'h8,    1'b1, 1'b0, 4'hF,    32'h20,  32'h0);
    vec(1'b1, 32'h20,   1'b0, 1'b0, 4'h0,    32'h0,   32'h0);
    vec(1'b0, 32'h0,    1'b1, 1'b1, 4'b1010, 32'h24,  32'hCAFE_F00D);
    vec(1'b1, 32'h24,   1'b0, 1'b0, 4'h0,    32'h0,   32'h0);
    idle();
    tick();

    // Reset while a read response is pending
    dreq(1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    chk1("mid_rst_gnt", data_gnt, 1'b1);
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk1("mid_rst_data_rvalid", data_rvalid, 1'b0);
    chk1("mid_rst_instr_rvalid", instr_rvalid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_no_rvalid", data_rvalid, 1'b0);
    tick();

    // Sustained contention
    ireq(32'h104);
    dreq(1'b0, 4'hF, 32'h208, 32'h0);
    win_on = 1'b1;
    repeat (20) tick();
    win_on = 1'b0;
    idle();
    tick();
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk32("cont_data_grants", 32'(cnt_d), 32'd10);
    chk32("cont_instr_grants", 32'(cnt_i), 32'd10);
`else
    chk32("cont_data_grants", 32'(cnt_d), 32'd16);
    chk32("cont_instr_grants", 32'(cnt_i), 32'd4);
`endif
    chk32("cont_pattern_errors", 32'(cnt_pat_err), 32'd0);
    chk32("both_gnt_cycles", 32'(cnt_both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
